// File: rtl/demux_latch.sv
// demux_latch: debounced key commits a 2-bit switch value into one of four held LED channels
module demux_latch #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sw,
  input  logic       btn,
  output logic [7:0] led,
  output logic [3:0] ch_valid,
  output logic       wr_ack
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic s1_q, s2_q, commit;
  logic [7:0] led_q;
  logic [3:0] valid_q;
  logic ack_q;
  logic unused_sw;
  assign unused_sw = ^sw[9:5];
  // two-flop synchronizer for the asynchronous key
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
    end
  end
  // debounce state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next-state: a level must persist DB_CYCLES counted cycles to be accepted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (s2_q) begin
        state_d = PRESS_WAIT;
        cnt_d   = CW'(1);
      end
      PRESS_WAIT: begin
        if (!s2_q) state_d = IDLE;
        else if (cnt_q == DB_MAX) state_d = HELD;
        else cnt_d = cnt_q + CW'(1);
      end
      HELD: if (!s2_q) begin
        state_d = RELEASE_WAIT;
        cnt_d   = CW'(1);
      end
      RELEASE_WAIT: begin
        if (s2_q) state_d = HELD;
        else if (cnt_q == DB_MAX) state_d = IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // a commit happens on the single edge the press is accepted
  always_comb begin
    commit = (state_q == PRESS_WAIT) && s2_q && (cnt_q == DB_MAX);
  end
  // channel storage: write the selected channel or clear everything
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      valid_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= commit;
      if (commit && sw[4]) begin
        led_q   <= '0;
        valid_q <= '0;
      end else if (commit) begin
        led_q[{sw[1:0], 1'b0} +: 2] <= sw[3:2];
        valid_q[sw[1:0]]            <= 1'b1;
      end
    end
  end
  assign led      = led_q;
  assign ch_valid = valid_q;
  assign wr_ack   = ack_q;
endmodule

// File: tb/tb_demux_latch.sv
// tb_demux_latch: table-driven, hand-sequenced and randomized checks against a run-length model
module tb_demux_latch;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] sw = '0;
  logic btn = 1'b0;
  logic [7:0] led;
  logic [3:0] ch_valid;
  logic wr_ack;
  int passed = 0;
  int total = 0;
  demux_latch #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .led(led), .ch_valid(ch_valid), .wr_ack(wr_ack)
  );
  always #5 clk = ~clk;
  // reference model: btn seen two edges late; a new level is accepted once it
  // has been seen on DB+1 consecutive edges; acceptance of high commits sw
  logic [1:0] m_ch [4] = '{default: 2'b00};
  logic [3:0] m_val = '0;
  logic m_ack = 1'b0;
  logic h1 = 1'b0, h2 = 1'b0, level = 1'b0;
  int run = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_ch = '{default: 2'b00};
      m_val = '0;
      m_ack = 1'b0;
      h1 = 1'b0;
      h2 = 1'b0;
      level = 1'b0;
      run = 0;
    end else begin
      m_ack = 1'b0;
      if (h2 != level) begin
        run = run + 1;
        if (run == DB + 1) begin
          level = h2;
          run = 0;
          if (h2) begin
            m_ack = 1'b1;
            if (sw[4]) begin
              m_ch = '{default: 2'b00};
              m_val = '0;
            end else begin
              m_ch[sw[1:0]] = sw[3:2];
              m_val[sw[1:0]] = 1'b1;
            end
          end
        end
      end else run = 0;
      h2 = h1;
      h1 = btn;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic r;
    logic b;
    logic [9:0] s;
    int n;
    logic [7:0] el;
    logic [3:0] ev;
    int ea;
  } seg_t;
  seg_t segs[$];
  initial begin
    int acks;
    int hold;
    logic lvl;
    segs.push_back('{1'b1, 1'b0, 10'h000, 2, 8'h00, 4'h0, 0});
    segs.push_back('{1'b0, 1'b0, 10'h000, 20, 8'h00, 4'h0, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000001110, 8, 8'h30, 4'h4, 1});
    segs.push_back('{1'b0, 1'b1, 10'b0000001110, 50, 8'h30, 4'h4, 0});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h30, 4'h4, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000000100, 8, 8'h31, 4'h5, 1});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h31, 4'h5, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000001001, 8, 8'h39, 4'h7, 1});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h39, 4'h7, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000001110, 8, 8'h39, 4'h7, 1});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h39, 4'h7, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000000011, 8, 8'h39, 4'hF, 1});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h39, 4'hF, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000010111, 8, 8'h00, 4'h0, 1});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h00, 4'h0, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000001100, 3, 8'h00, 4'h0, 0});
    segs.push_back('{1'b0, 1'b0, 10'b0000001100, 2, 8'h00, 4'h0, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000001100, 3, 8'h00, 4'h0, 0});
    segs.push_back('{1'b0, 1'b0, 10'b0000001100, 8, 8'h00, 4'h0, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000001100, 10, 8'h03, 4'h1, 1});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h03, 4'h1, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000000101, 8, 8'h07, 4'h3, 1});
    segs.push_back('{1'b0, 1'b0, 10'h000, 2, 8'h07, 4'h3, 0});
    segs.push_back('{1'b0, 1'b1, 10'h000, 3, 8'h07, 4'h3, 0});
    segs.push_back('{1'b0, 1'b0, 10'h000, 2, 8'h07, 4'h3, 0});
    segs.push_back('{1'b0, 1'b1, 10'h000, 3, 8'h07, 4'h3, 0});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h07, 4'h3, 0});
    segs.push_back('{1'b0, 1'b1, 10'b0000001011, 8, 8'h87, 4'hB, 1});
    segs.push_back('{1'b0, 1'b0, 10'h000, 10, 8'h87, 4'hB, 0});
    foreach (segs[i]) begin
      rst = segs[i].r;
      btn = segs[i].b;
      sw = segs[i].s;
      acks = 0;
      for (int c = 0; c < segs[i].n; c++) begin
        tick();
        acks += int'(wr_ack);
      end
      chk($sformatf("seg%0d_led", i), 32'(led), 32'(segs[i].el));
      chk($sformatf("seg%0d_valid", i), 32'(ch_valid), 32'(segs[i].ev));
      chk($sformatf("seg%0d_acks", i), 32'(acks), 32'(segs[i].ea));
    end
    btn = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      rst = (e == 4);
      sw = (e >= 8) ? 10'b0000001101 : 10'b0000001000;
      tick();
      chk($sformatf("rst_seq_ack_e%0d", e), 32'(wr_ack), 32'(e == 11));
      if (e == 4) chk("rst_seq_led_cleared", 32'(led), 32'h00);
    end
    chk("rst_seq_led", 32'(led), 32'h0C);
    chk("rst_seq_valid", 32'(ch_valid), 32'h2);
    btn = 1'b0;
    rst = 1'b0;
    hold = 0;
    lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        lvl = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      btn = lvl;
      sw = 10'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      chk("rand_led", 32'(led), 32'({m_ch[3], m_ch[2], m_ch[1], m_ch[0]}));
      chk("rand_valid", 32'(ch_valid), 32'(m_val));
      chk("rand_ack", 32'(wr_ack), 32'(m_ack));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux_latch.md
Name: demux_latch

Overview:
- Inverse of the switch-driven 4:1 LED selector: takes one 2-bit value from the switches and routes it into one of four held 2-bit output channels on the LEDs.
- A write is committed by a debounced push-button press, one commit per press.
- A clear-all function is selected from a switch.
- Sits between the board switch/key inputs and the 8-bit LED bank.

Parameters:
- DB_CYCLES, 16, consecutive stable-high (or stable-low) clk cycles of the synchronized key before a press (or release) is accepted; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- sw  input  10  sw[1:0] destination channel, sw[3:2] data, sw[4] clear-all select, sw[9:5] ignored
- btn  input  1  raw asynchronous write key, active-high, may bounce
- led  output  8  channel k held at led[2k+1:2k], k=0..3
- ch_valid  output  4  bit k=1 when channel k has been written since reset or the last clear
- wr_ack  output  1  one-cycle pulse on the cycle led/ch_valid update from a commit

Behaviour:
- Reset (rst=1 at posedge): led=0, ch_valid=0, wr_ack=0, both synchronizer flops=0, FSM=IDLE, cnt=0. Reset wins over any other event that cycle.
- Synchronizer: btn passes through two flops to give btn_s. Only btn_s feeds the FSM.
- Debounce counter cnt is clog2(DB_CYCLES+1) bits wide. It saturates by construction and never wraps.
- FSM states and transitions:
  - IDLE: btn_s=1 -> PRESS_WAIT, cnt=1. Otherwise stay.
  - PRESS_WAIT: btn_s=0 -> IDLE (bounce, no commit). btn_s=1 and cnt==DB_CYCLES -> HELD and commit. Otherwise cnt+1.
  - HELD: btn_s=0 -> RELEASE_WAIT, cnt=1. Otherwise stay; no further commits regardless of switch changes.
  - RELEASE_WAIT: btn_s=1 -> HELD (release bounce, no commit). btn_s=0 and cnt==DB_CYCLES -> IDLE. Otherwise cnt+1.
- Latency: btn first sampled high at edge e0 and held -> FSM sees btn_s=1 at e2 -> commit at edge e(DB_CYCLES+2).
  - led, ch_valid and wr_ack are registered, so they change at that edge.
  - wr_ack is high for exactly that one cycle.
- Commit action: sw is sampled at the commit edge itself; sw changes during debounce are irrelevant.
  - sw[4]=0: channel sw[1:0] <= sw[3:2]; ch_valid[sw[1:0]] <= 1; other channels unchanged.
  - sw[4]=1: all four channels <= 0 and ch_valid <= 0, regardless of sw[3:0]. wr_ack still pulses.
- Writing data 2'b00 is a real write: ch_valid bit is set.
- Re-writing a channel overwrites it; last commit wins.
- Holding btn forever gives exactly one commit. A new commit requires a full accepted release (IDLE) first.
- Glitches shorter than DB_CYCLES consecutive synchronized cycles, high or low, never produce a commit or a release.
- Reset mid-debounce or mid-hold: no commit; state returns to IDLE.
  - If btn is still high after rst deasserts, it is treated as a fresh press and commits once after the normal latency.
- led and ch_valid hold their values indefinitely between commits; there is no auto-clear.

Test Plan (DB_CYCLES=4):
- Reset then idle 20 cycles, btn=0 -> led=8'h00, ch_valid=4'h0, wr_ack never high.
- sw=10'b00000_11_10, btn high at e0 and held -> at e6 led=8'b00110000, ch_valid=4'b0100, wr_ack=1 for one cycle. Holding btn 50 more cycles -> no further wr_ack.
- Four presses, each with full release, writing ch0=01, ch1=10, ch2=11, ch3=00 -> led=8'b00111001, ch_valid=4'hF. Then a press with sw[4]=1 -> led=0, ch_valid=0, one wr_ack.
- btn pulses high for 3 cycles, low 2, high 3 (never 4 stable) -> no wr_ack, led unchanged. Then hold high -> exactly one commit.
- Press accepted, then release with 2-cycle low bounces inside HELD/RELEASE_WAIT, then re-press -> exactly one commit per accepted press (2 total).
- Assert rst at e4 during PRESS_WAIT with btn held high; deassert at e5 -> no commit before reset, led=0. One commit DB_CYCLES+2 edges after reset release, using sw at that edge.
